// File: rtl/rvvi_mon_pkg.sv
// -----------------------------------------------------------------------------
// rvvi_mon_pkg : shared constants and helpers for the RVVI trace monitor
// Revision     : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package rvvi_mon_pkg;

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  // insn[1:0] value that marks a full-width (non-compressed) instruction
  localparam logic [1:0] RVC_QUAD_NONE = 2'b11;

  // Increment that sticks at the all-ones value of a WIDTH-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] val,
                                          input int unsigned width);
    logic [63:0] lim;
    lim = (width >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << width) - 64'd1);
    return (val >= lim) ? lim : val + 64'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rvvi_wb_cov.sv
// -----------------------------------------------------------------------------
// rvvi_wb_cov : sticky write / zero-value / all-ones-value hit maps for one
//               32-entry register file
// Revision    : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module rvvi_wb_cov
  import rvvi_mon_pkg::*;
#(
  parameter int W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              sample,
  input  logic [31:0]       wb,
  input  logic [32*W-1:0]   wdata,
  output logic [31:0]       wr_hit,
  output logic [31:0]       zero_hit,
  output logic [31:0]       ones_hit
);

  logic [31:0] zero_now;
  logic [31:0] ones_now;
  logic [31:0] wr_hit_q,   wr_hit_d;
  logic [31:0] zero_hit_q, zero_hit_d;
  logic [31:0] ones_hit_q, ones_hit_d;

  // Value classes only count for registers actually written this record
  generate
    for (genvar i = 0; i < 32; i++) begin : g_reg
      assign zero_now[i] = wb[i] & (wdata[i*W +: W] == {W{1'b0}});
      assign ones_now[i] = wb[i] & (wdata[i*W +: W] == {W{1'b1}});
    end
  endgenerate

  always_comb begin
    wr_hit_d   = wr_hit_q;
    zero_hit_d = zero_hit_q;
    ones_hit_d = ones_hit_q;
    if (clear) begin
      wr_hit_d   = '0;
      zero_hit_d = '0;
      ones_hit_d = '0;
    end else if (sample) begin
      wr_hit_d   = wr_hit_q   | wb;
      zero_hit_d = zero_hit_q | zero_now;
      ones_hit_d = ones_hit_q | ones_now;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_hit_q   <= '0;
      zero_hit_q <= '0;
      ones_hit_q <= '0;
    end else begin
      wr_hit_q   <= wr_hit_d;
      zero_hit_q <= zero_hit_d;
      ones_hit_q <= ones_hit_d;
    end
  end

  assign wr_hit   = wr_hit_q;
  assign zero_hit = zero_hit_q;
  assign ones_hit = ones_hit_q;

endmodule

`default_nettype wire

// File: rtl/rvvi_trace_monitor.sv
// -----------------------------------------------------------------------------
// rvvi_trace_monitor : retirement coverage collector and trace protocol checker
//                      for a single-hart, single-retire-port RVVI trace
// Revision           : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module rvvi_trace_monitor
  import rvvi_mon_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int FLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                valid,
  input  logic [63:0]         order,
  input  logic [31:0]         insn,
  input  logic                trap,
  input  logic                debug_mode,
  input  logic [XLEN-1:0]     pc_rdata,
  input  logic [1:0]          mode,
  input  logic                m_ext_intr,
  input  logic                s_ext_intr,
  input  logic                m_timer_intr,
  input  logic                m_soft_intr,
  input  logic [31:0]         x_wb,
  input  logic [32*XLEN-1:0]  x_wdata,
  input  logic [31:0]         f_wb,
  input  logic [32*FLEN-1:0]  f_wdata,
  output logic [CNT_W-1:0]    retired_cnt,
  output logic [CNT_W-1:0]    trap_cnt,
  output logic [31:0]         opcode_hit,
  output logic [2:0]          rvc_hit,
  output logic [3:0]          mode_hit,
  output logic [3:0]          intr_hit,
  output logic [31:0]         x_wr_hit,
  output logic [31:0]         x_zero_hit,
  output logic [31:0]         x_ones_hit,
  output logic [31:0]         f_wr_hit,
  output logic                order_err,
  output logic                x0_wr_err,
  output logic                pc_align_err
);

  logic [CNT_W-1:0] retired_q, retired_d;
  logic [CNT_W-1:0] trap_q,    trap_d;
  logic [31:0]      opcode_q,  opcode_d;
  logic [2:0]       rvc_q,     rvc_d;
  logic [3:0]       mode_q,    mode_d;
  logic [3:0]       intr_q,    intr_d;
  logic [63:0]      prev_order_q, prev_order_d;
  logic             first_q,   first_d;
  logic             order_err_q, order_err_d;
  logic             x0_err_q,  x0_err_d;
  logic             pc_err_q,  pc_err_d;

  logic             cov_sample;
  logic [31:0]      f_zero_unused;
  logic [31:0]      f_ones_unused;
  logic             unused_inputs;

  // Debug-mode records still feed the error checks but no coverage
  assign cov_sample = valid & ~debug_mode;

  always_comb begin
    retired_d    = retired_q;
    trap_d       = trap_q;
    opcode_d     = opcode_q;
    rvc_d        = rvc_q;
    mode_d       = mode_q;
    intr_d       = intr_q;
    prev_order_d = prev_order_q;
    first_d      = first_q;
    order_err_d  = order_err_q;
    x0_err_d     = x0_err_q;
    pc_err_d     = pc_err_q;

    if (clear) begin
      retired_d    = '0;
      trap_d       = '0;
      opcode_d     = '0;
      rvc_d        = '0;
      mode_d       = '0;
      intr_d       = '0;
      prev_order_d = '0;
      first_d      = 1'b1;
      order_err_d  = 1'b0;
      x0_err_d     = 1'b0;
      pc_err_d     = 1'b0;
    end else if (valid) begin
      retired_d    = CNT_W'(sat_inc(64'(retired_q), CNT_W));
      if (!first_q && (order != prev_order_q + 64'd1)) begin
        order_err_d = 1'b1;
      end
      prev_order_d = order;
      first_d      = 1'b0;
      if (x_wb[0])      x0_err_d = 1'b1;
      if (pc_rdata[0])  pc_err_d = 1'b1;

      if (!debug_mode) begin
        if (trap) begin
          trap_d = CNT_W'(sat_inc(64'(trap_q), CNT_W));
        end else if (insn[1:0] == RVC_QUAD_NONE) begin
          opcode_d[insn[6:2]] = 1'b1;
        end else begin
          rvc_d[insn[1:0]] = 1'b1;
        end

        case (mode)
          PRIV_U:  mode_d[0] = 1'b1;
          PRIV_S:  mode_d[1] = 1'b1;
          PRIV_M:  mode_d[3] = 1'b1;
          default: mode_d[2] = 1'b1;
        endcase

        intr_d = intr_q | {m_soft_intr, m_timer_intr, s_ext_intr, m_ext_intr};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q    <= '0;
      trap_q       <= '0;
      opcode_q     <= '0;
      rvc_q        <= '0;
      mode_q       <= '0;
      intr_q       <= '0;
      prev_order_q <= '0;
      first_q      <= 1'b1;
      order_err_q  <= 1'b0;
      x0_err_q     <= 1'b0;
      pc_err_q     <= 1'b0;
    end else begin
      retired_q    <= retired_d;
      trap_q       <= trap_d;
      opcode_q     <= opcode_d;
      rvc_q        <= rvc_d;
      mode_q       <= mode_d;
      intr_q       <= intr_d;
      prev_order_q <= prev_order_d;
      first_q      <= first_d;
      order_err_q  <= order_err_d;
      x0_err_q     <= x0_err_d;
      pc_err_q     <= pc_err_d;
    end
  end

  rvvi_wb_cov #(.W(XLEN)) u_x_cov (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .sample   (cov_sample),
    .wb       (x_wb),
    .wdata    (x_wdata),
    .wr_hit   (x_wr_hit),
    .zero_hit (x_zero_hit),
    .ones_hit (x_ones_hit)
  );

  // FP data values are not tracked; only the write map leaves this block
  rvvi_wb_cov #(.W(FLEN)) u_f_cov (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .sample   (cov_sample),
    .wb       (f_wb),
    .wdata    (f_wdata),
    .wr_hit   (f_wr_hit),
    .zero_hit (f_zero_unused),
    .ones_hit (f_ones_unused)
  );

  assign unused_inputs = ^{insn[31:7], pc_rdata[XLEN-1:1], f_zero_unused, f_ones_unused};

  assign retired_cnt  = retired_q;
  assign trap_cnt     = trap_q;
  assign opcode_hit   = opcode_q;
  assign rvc_hit      = rvc_q;
  assign mode_hit     = mode_q;
  assign intr_hit     = intr_q;
  assign order_err    = order_err_q;
  assign x0_wr_err    = x0_err_q;
  assign pc_align_err = pc_err_q;

endmodule

`default_nettype wire

// File: tb/tb_rvvi_trace_monitor.sv
// -----------------------------------------------------------------------------
// tb_rvvi_trace_monitor : directed self-checking bench for rvvi_trace_monitor
// Revision              : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_rvvi_trace_monitor;

  localparam int XLEN  = 64;
  localparam int FLEN  = 32;
  localparam int CNT_W = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                clear;
  logic                valid;
  logic [63:0]         order;
  logic [31:0]         insn;
  logic                trap;
  logic                debug_mode;
  logic [XLEN-1:0]     pc_rdata;
  logic [1:0]          mode;
  logic                m_ext_intr, s_ext_intr, m_timer_intr, m_soft_intr;
  logic [31:0]         x_wb;
  logic [32*XLEN-1:0]  x_wdata;
  logic [31:0]         f_wb;
  logic [32*FLEN-1:0]  f_wdata;

  logic [CNT_W-1:0]    retired_cnt, trap_cnt;
  logic [31:0]         opcode_hit;
  logic [2:0]          rvc_hit;
  logic [3:0]          mode_hit, intr_hit;
  logic [31:0]         x_wr_hit, x_zero_hit, x_ones_hit, f_wr_hit;
  logic                order_err, x0_wr_err, pc_align_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rvvi_trace_monitor #(.XLEN(XLEN), .FLEN(FLEN), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .valid        (valid),
    .order        (order),
    .insn         (insn),
    .trap         (trap),
    .debug_mode   (debug_mode),
    .pc_rdata     (pc_rdata),
    .mode         (mode),
    .m_ext_intr   (m_ext_intr),
    .s_ext_intr   (s_ext_intr),
    .m_timer_intr (m_timer_intr),
    .m_soft_intr  (m_soft_intr),
    .x_wb         (x_wb),
    .x_wdata      (x_wdata),
    .f_wb         (f_wb),
    .f_wdata      (f_wdata),
    .retired_cnt  (retired_cnt),
    .trap_cnt     (trap_cnt),
    .opcode_hit   (opcode_hit),
    .rvc_hit      (rvc_hit),
    .mode_hit     (mode_hit),
    .intr_hit     (intr_hit),
    .x_wr_hit     (x_wr_hit),
    .x_zero_hit   (x_zero_hit),
    .x_ones_hit   (x_ones_hit),
    .f_wr_hit     (f_wr_hit),
    .order_err    (order_err),
    .x0_wr_err    (x0_wr_err),
    .pc_align_err (pc_align_err)
  );

  // Every observable output flattened, for all-zero checks
  wire [181:0] all_out = {retired_cnt, trap_cnt, opcode_hit, rvc_hit, mode_hit, intr_hit,
                          x_wr_hit, x_zero_hit, x_ones_hit, f_wr_hit,
                          order_err, x0_wr_err, pc_align_err};

  // One record per call; side-band inputs set beforehand are returned to idle after the edge
  task automatic send(input logic [63:0] ord, input logic [31:0] ins,
                      input logic tr, input logic dbg, input logic [1:0] md);
    valid = 1'b1; order = ord; insn = ins; trap = tr; debug_mode = dbg; mode = md;
    @(posedge clk); #1;
    valid = 1'b0; trap = 1'b0; debug_mode = 1'b0;
    x_wb = '0; f_wb = '0; pc_rdata = 64'h1000;
    {m_soft_intr, m_timer_intr, s_ext_intr, m_ext_intr} = 4'b0000;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; valid = 1'b0; order = '0; insn = '0; trap = 1'b0;
    debug_mode = 1'b0; pc_rdata = 64'h1000; mode = 2'd3;
    {m_soft_intr, m_timer_intr, s_ext_intr, m_ext_intr} = 4'b0000;
    x_wb = '0; x_wdata = '0; f_wb = '0; f_wdata = '0;
    repeat (2) @(posedge clk); #1;
    total++;
    if (all_out !== 182'd0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=0", all_out);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    do_clear();
    send(64'd5, 32'h0000_0013, 1'b0, 1'b0, 2'd3);
    total++;
    if (retired_cnt !== 4'd1) begin
      bad++; $display("FAIL basic_latency got=%0d exp=1", retired_cnt);
    end
    send(64'd6, 32'h0000_0013, 1'b0, 1'b0, 2'd3);
    send(64'd7, 32'h0000_0013, 1'b0, 1'b0, 2'd3);
    @(posedge clk); #1;
    total++;
    if (retired_cnt !== 4'd3) begin
      bad++; $display("FAIL basic_retired got=%0d exp=3", retired_cnt);
    end
    total++;
    if (opcode_hit !== 32'h0000_0010) begin
      bad++; $display("FAIL basic_opcode got=%h exp=00000010", opcode_hit);
    end
    total++;
    if (mode_hit !== 4'b1000) begin
      bad++; $display("FAIL basic_mode got=%b exp=1000", mode_hit);
    end
    total++;
    if (order_err !== 1'b0 || trap_cnt !== 4'd0 || rvc_hit !== 3'd0) begin
      bad++; $display("FAIL basic_quiet got=%b/%0d/%b exp=0/0/000", order_err, trap_cnt, rvc_hit);
    end
  endtask

  task automatic test_order();
    do_clear();
    send(64'd10, 32'h0000_0013, 1'b0, 1'b0, 2'd3);
    total++;
    if (order_err !== 1'b0) begin
      bad++; $display("FAIL order_first got=%b exp=0", order_err);
    end
    send(64'd12, 32'h0000_0013, 1'b0, 1'b0, 2'd3);
    total++;
    if (order_err !== 1'b1) begin
      bad++; $display("FAIL order_gap got=%b exp=1", order_err);
    end
    send(64'd13, 32'h0000_0013, 1'b0, 1'b0, 2'd3);
    send(64'd14, 32'h0000_0013, 1'b0, 1'b0, 2'd3);
    total++;
    if (order_err !== 1'b1) begin
      bad++; $display("FAIL order_sticky got=%b exp=1", order_err);
    end
    do_clear();
    send(64'hFFFF_FFFF_FFFF_FFFF, 32'h0000_0013, 1'b0, 1'b0, 2'd3);
    send(64'd0, 32'h0000_0013, 1'b0, 1'b0, 2'd3);
    total++;
    if (order_err !== 1'b0) begin
      bad++; $display("FAIL order_wrap got=%b exp=0", order_err);
    end
  endtask

  task automatic test_trap_rvc();
    do_clear();
    send(64'd1, 32'h0000_0001, 1'b0, 1'b0, 2'd3);
    send(64'd2, 32'h0000_0073, 1'b1, 1'b0, 2'd3);
    total++;
    if (rvc_hit !== 3'b010) begin
      bad++; $display("FAIL rvc_quadrant got=%b exp=010", rvc_hit);
    end
    total++;
    if (trap_cnt !== 4'd1) begin
      bad++; $display("FAIL trap_count got=%0d exp=1", trap_cnt);
    end
    total++;
    if (opcode_hit !== 32'h0) begin
      bad++; $display("FAIL trap_no_opcode got=%h exp=00000000", opcode_hit);
    end
    total++;
    if (retired_cnt !== 4'd2) begin
      bad++; $display("FAIL trap_retired got=%0d exp=2", retired_cnt);
    end
  endtask

  task automatic test_writeback();
    do_clear();
    x_wdata = '0;
    x_wdata[2*XLEN +: XLEN] = {XLEN{1'b1}};
    x_wb = 32'h0000_0006;
    f_wb = 32'h8000_0001;
    {m_soft_intr, m_timer_intr, s_ext_intr, m_ext_intr} = 4'b1010;
    send(64'd1, 32'h0000_0013, 1'b0, 1'b0, 2'd2);
    total++;
    if (x0_wr_err !== 1'b0 || x_wr_hit !== 32'h6) begin
      bad++; $display("FAIL wb_first got=%b/%h exp=0/00000006", x0_wr_err, x_wr_hit);
    end
    total++;
    if (mode_hit !== 4'b0100 || intr_hit !== 4'b1010) begin
      bad++; $display("FAIL mode2_intr got=%b/%b exp=0100/1010", mode_hit, intr_hit);
    end
    total++;
    if (f_wr_hit !== 32'h8000_0001) begin
      bad++; $display("FAIL f_wr got=%h exp=80000001", f_wr_hit);
    end
    x_wdata[0 +: XLEN] = 64'd5;
    x_wb = 32'h0000_0001;
    send(64'd2, 32'h0000_0013, 1'b0, 1'b0, 2'd3);
    total++;
    if (x_wr_hit !== 32'h7) begin
      bad++; $display("FAIL wb_wr got=%h exp=00000007", x_wr_hit);
    end
    total++;
    if (x_zero_hit !== 32'h2 || x_ones_hit !== 32'h4) begin
      bad++; $display("FAIL wb_values got=%h/%h exp=00000002/00000004", x_zero_hit, x_ones_hit);
    end
    total++;
    if (x0_wr_err !== 1'b1 || pc_align_err !== 1'b0) begin
      bad++; $display("FAIL wb_x0_err got=%b/%b exp=1/0", x0_wr_err, pc_align_err);
    end
    x_wb = 32'h0000_0008;
    pc_rdata = 64'h1001;
    send(64'd3, 32'h0000_0013, 1'b0, 1'b1, 2'd0);
    total++;
    if (pc_align_err !== 1'b1 || x_wr_hit !== 32'h7 || mode_hit !== 4'b1100) begin
      bad++; $display("FAIL debug_err_only got=%b/%h/%b exp=1/00000007/1100", pc_align_err, x_wr_hit, mode_hit);
    end
    x_wdata = '0;
  endtask

  task automatic test_saturate_clear();
    do_clear();
    for (int i = 0; i < 15; i++) send(64'(i + 1), 32'h0000_0013, 1'b1, 1'b0, 2'd3);
    total++;
    if (retired_cnt !== 4'hF) begin
      bad++; $display("FAIL sat_reach got=%h exp=f", retired_cnt);
    end
    for (int i = 15; i < 20; i++) send(64'(i + 1), 32'h0000_0013, 1'b1, 1'b0, 2'd3);
    total++;
    if (retired_cnt !== 4'hF || trap_cnt !== 4'hF) begin
      bad++; $display("FAIL sat_hold got=%h/%h exp=f/f", retired_cnt, trap_cnt);
    end
    clear = 1'b1;
    x_wb = 32'h1;
    send(64'd50, 32'h0000_0013, 1'b0, 1'b0, 2'd3);
    clear = 1'b0;
    total++;
    if (all_out !== 182'd0) begin
      bad++; $display("FAIL clear_with_valid got=%h exp=0", all_out);
    end
    send(64'd200, 32'h0000_0013, 1'b0, 1'b0, 2'd3);
    total++;
    if (retired_cnt !== 4'd1 || order_err !== 1'b0) begin
      bad++; $display("FAIL clear_first_rec got=%0d/%b exp=1/0", retired_cnt, order_err);
    end
  endtask

  task automatic test_debug_async_reset();
    do_clear();
    x_wdata[1*XLEN +: XLEN] = {XLEN{1'b1}};
    x_wb = 32'h2;
    f_wb = 32'h4;
    {m_soft_intr, m_timer_intr, s_ext_intr, m_ext_intr} = 4'b1111;
    send(64'd1, 32'h0000_0013, 1'b1, 1'b1, 2'd3);
    send(64'd2, 32'h0000_0001, 1'b0, 1'b1, 2'd1);
    total++;
    if (retired_cnt !== 4'd2) begin
      bad++; $display("FAIL debug_retired got=%0d exp=2", retired_cnt);
    end
    total++;
    if (all_out[177:0] !== 178'd0) begin
      bad++; $display("FAIL debug_suppress got=%h exp=0", all_out[177:0]);
    end
    valid = 1'b1; order = 64'd3; debug_mode = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (all_out !== 182'd0) begin
      bad++; $display("FAIL async_reset got=%h exp=0", all_out);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; valid = 1'b0; debug_mode = 1'b0;
    x_wdata = '0;
    send(64'd77, 32'h0000_0013, 1'b0, 1'b0, 2'd3);
    total++;
    if (retired_cnt !== 4'd1 || order_err !== 1'b0) begin
      bad++; $display("FAIL post_reset_first got=%0d/%b exp=1/0", retired_cnt, order_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_order();
    test_trap_rvc();
    test_writeback();
    test_saturate_clear();
    test_debug_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rvvi_trace_monitor.md
Name: rvvi_trace_monitor

Overview:
- Synthesizable retirement monitor and coverage collector attached to an RVVI-style trace (one hart, one retire port).
- Samples each retired instruction and accumulates coverage state as counters and sticky hit bitmaps.
- Covers retirement, traps, major opcodes, compressed quadrants, privilege modes, interrupts and register writebacks.
- Flags trace protocol violations: order discontinuity, x0 writeback, misaligned PC.
- Sits between the trace source (core or trace replayer) and the coverage/report logic.

Parameters:
- XLEN, 64, integer register and PC width (32 or 64).
- FLEN, 32, FP register width (32, 64 or 128).
- CNT_W, 32, width of the saturating event counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous clear of all coverage state; same values as reset.
- valid  in  1  a retirement record is present this cycle.
- order  in  64  retirement sequence number.
- insn  in  32  instruction word; a compressed instruction occupies bits [15:0].
- trap  in  1  the instruction trapped.
- debug_mode  in  1  the hart is in debug mode.
- pc_rdata  in  XLEN  PC of the retired instruction.
- mode  in  2  privilege mode: 0=U, 1=S, 3=M, 2=reserved.
- m_ext_intr, s_ext_intr, m_timer_intr, m_soft_intr  in  1 each  pending interrupt indications.
- x_wb  in  32  integer register writeback mask.
- x_wdata  in  32*XLEN  packed integer writeback data; register i is at [i*XLEN +: XLEN].
- f_wb  in  32  FP register writeback mask.
- f_wdata  in  32*FLEN  packed FP writeback data.
- retired_cnt  out  CNT_W  number of valid records.
- trap_cnt  out  CNT_W  number of valid records with trap set.
- opcode_hit  out  32  sticky; bit insn[6:2] set for each 32-bit instruction (insn[1:0]==2'b11) retired without trap.
- rvc_hit  out  3  sticky; bit insn[1:0] set for each compressed instruction retired without trap.
- mode_hit  out  4  sticky; bit mode set per valid record.
- intr_hit  out  4  sticky; bits {m_soft, m_timer, s_ext, m_ext} OR-ed in per valid record.
- x_wr_hit  out  32  sticky OR of x_wb.
- x_zero_hit  out  32  sticky; register i was written with the value 0.
- x_ones_hit  out  32  sticky; register i was written with all-ones.
- f_wr_hit  out  32  sticky OR of f_wb.
- order_err  out  1  sticky; order discontinuity detected.
- x0_wr_err  out  1  sticky; a record had x_wb[0] set.
- pc_align_err  out  1  sticky; a record had pc_rdata[0] set.

Behaviour:
- Reset values: all outputs 0; internal first-record flag = 1; prev_order = 0.
- clear has priority over a simultaneous valid. A record arriving in the same cycle as clear is discarded.
- When valid=0, no state changes and the wdata inputs are ignored.
- When valid=1, all updates become visible one cycle after the sampling edge (registered outputs, latency 1).
- Counters are CNT_W bits wide and saturate at all-ones; they never wrap.
- Records with debug_mode=1 update only retired_cnt and the error flags. All other coverage is suppressed.
- Opcode coverage is taken only when trap=0. trap_cnt counts every trapped record.
- Order check:
  - On the first valid record after reset or clear, load prev_order and set no error.
  - On each later record, if order != prev_order+1 (64-bit wrap allowed), set order_err.
  - prev_order is updated on every record.
- Register writeback:
  - x_zero_hit and x_ones_hit consider only registers whose x_wb bit is set.
  - Bit 0 is recorded in x_wr_hit, x_zero_hit and x_ones_hit like any other bit, and additionally sets x0_wr_err.
- f_wdata is accepted but only f_wb is tracked.
- mode=2 sets mode_hit[2]; no error is raised.
- Reset asserted mid-stream clears everything immediately, asynchronously.

Decomposition:
- Package rvvi_mon_pkg holds:
  - privilege mode constants PRIV_U, PRIV_S, PRIV_M;
  - the RVC quadrant code constant;
  - the saturating increment function.
- One sub-module, rvvi_wb_cov, holds one instance per register file. It takes the wb mask and packed data and produces the write / zero / ones hit bitmaps; it is parameterized by data width.

Test Plan:
- Reset, then three records with order 5,6,7, insn 0x00000013, mode 3 -> retired_cnt=3, opcode_hit=0x00000010, mode_hit=4'b1000, order_err=0.
- Records with order 10 then 12 -> order_err=1, and it stays 1 after further contiguous records.
- insn 0x00000001 (trap=0) and insn 0x00000073 (trap=1) -> rvc_hit=3'b010, trap_cnt=1, opcode_hit[28]=0.
- x_wb=0x00000006 with x1=0 and x2=all-ones, then x_wb=0x1 -> x_wr_hit=0x7, x_zero_hit bit1, x_ones_hit bit2, x0_wr_err=1.
- CNT_W=4: 20 valid records -> retired_cnt=4'hF; then clear together with valid -> all outputs 0 on the next cycle.
- rst_n pulsed low asynchronously mid-stream with debug_mode=1 records -> outputs 0 immediately; debug records before the pulse had left only retired_cnt nonzero.
